// File: rtl/dsp_frame_sequencer_pkg.sv
// Shared types and constants for the DSP frame sequencer.
// The sequencer hands out DSPCore start strobes and coefficient writes.
package dsp_frame_sequencer_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 36;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
    } param_wr_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

endpackage

// File: rtl/dsp_frame_sequencer_if.sv
// Host coefficient-write bus.
// The host drives it through the master modport, and the sequencer accepts writes through the slave modport.
interface dsp_frame_sequencer_if
    import dsp_frame_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );

endinterface

// File: rtl/dsp_frame_sequencer_param_fifo.sv
// Show-ahead synchronous FIFO that holds queued coefficient writes.
// A flush empties it in one cycle.
module dsp_frame_sequencer_param_fifo
    import dsp_frame_sequencer_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF + 1,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/dsp_frame_sequencer.sv
// Issues DSPCore start pulses. Committed coefficient groups are applied only in the gap after a frame.
// As a result, a frame never runs with a partially written group.
module dsp_frame_sequencer
    import dsp_frame_sequencer_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_req,
    output logic                 dsp_start,
    input  logic                 dsp_done,
    dsp_frame_sequencer_if.slave host,
    output logic                 coef_we,
    output logic [ADDR_W-1:0]    coef_addr,
    output logic [DATA_W-1:0]    coef_data,
    output logic                 late_start,
    output logic                 group_err,
    input  logic                 err_clr
);

    localparam int ENTRY_W = ADDR_W + DATA_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   committed;
    logic [CNT_W-1:0]   committed_nxt;
    logic               start_pend;
    logic               start_dly;
    logic               issue_start;
    logic               delay_start;
    logic               late_set;
    logic               pend_now;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               flush;
    logic               push_last;
    logic               pop_last;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] head;

    assign host.wr_ready = !fifo_full;
    assign push          = host.wr_valid && !fifo_full;
    assign push_last     = push && host.wr_last;
    assign fifo_din      = {host.wr_addr, host.wr_data, host.wr_last};
    assign pop           = (state == ST_APPLY) && !fifo_empty;
    assign pop_last      = pop && head[0];
    assign pend_now      = start_pend || frame_req;

    // A full FIFO without a committed group can never drain, so that group is dropped.
    assign flush = fifo_full && (committed == '0);

    dsp_frame_sequencer_param_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        committed_nxt = committed;
        if (push_last && !pop_last) begin
            committed_nxt = committed + CNT_ONE;
        end else if (!push_last && pop_last) begin
            committed_nxt = committed - CNT_ONE;
        end
    end

    // A start that was held back behind a group waits one cycle after the last pop.
    // This keeps dsp_start one cycle after the final coef_we.
    always_comb begin
        state_nxt   = state;
        issue_start = 1'b0;
        delay_start = 1'b0;
        late_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_req) begin
                    issue_start = 1'b1;
                    state_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dsp_done && !start_dly) begin
                    if (pend_now) begin
                        issue_start = 1'b1;
                        late_set    = 1'b1;
                    end else if (committed != '0) begin
                        state_nxt = ST_APPLY;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_APPLY: begin
                if (pop_last) begin
                    if (pend_now) begin
                        delay_start = 1'b1;
                        late_set    = 1'b1;
                        state_nxt   = ST_RUN;
                    end else if (committed_nxt == '0) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            committed  <= '0;
            start_pend <= 1'b0;
            start_dly  <= 1'b0;
            dsp_start  <= 1'b0;
        end else begin
            state     <= state_nxt;
            committed <= committed_nxt;
            start_dly <= delay_start;
            dsp_start <= issue_start || start_dly;
            if (issue_start || delay_start) begin
                start_pend <= 1'b0;
            end else if (frame_req && (state != ST_IDLE)) begin
                start_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_we    <= 1'b0;
            coef_addr  <= '0;
            coef_data  <= '0;
            late_start <= 1'b0;
            group_err  <= 1'b0;
        end else begin
            coef_we <= pop;
            if (pop) begin
                coef_addr <= head[ENTRY_W-1 -: ADDR_W];
                coef_data <= head[DATA_W:1];
            end
            if (late_set) begin
                late_start <= 1'b1;
            end else if (err_clr) begin
                late_start <= 1'b0;
            end
            if (flush) begin
                group_err <= 1'b1;
            end else if (err_clr) begin
                group_err <= 1'b0;
            end
        end
    end

endmodule
